// File: rtl/ysyx_23060059_pkg.sv
// Shared definitions for the write-back unit slice.
//   - CSR index constants (mstatus, mtvec, mepc, mcause)
//   - Default trap cause and boot PC
//   - WBU FSM state encoding
//   - Packed record of one retiring instruction as seen by the WBU
package ysyx_23060059_pkg;

    localparam int XLEN       = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int CSR_ADDR_W = 2;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 2'd0;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC   = 2'd1;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 2'd2;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 2'd3;

    localparam logic [XLEN-1:0] ECALL_CAUSE   = 32'd11;
    localparam logic [XLEN-1:0] RESET_PC      = 32'h3000_0000;
    // MPP = 2'b11 (machine mode) out of reset.
    localparam logic [XLEN-1:0] MSTATUS_RESET = 32'h0000_1800;

    typedef enum logic [1:0] {
        WBU_IDLE     = 2'd0,
        WBU_COMMIT   = 2'd1,
        WBU_REDIRECT = 2'd2,
        WBU_HALT     = 2'd3
    } wbu_state_e;

    typedef struct packed {
        logic [XLEN-1:0]       wd;
        logic [XLEN-1:0]       csr_wd;
        logic [GPR_ADDR_W-1:0] rd;
        logic [CSR_ADDR_W-1:0] csr_rd;
        logic                  reg_en;
        logic                  csreg_en;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       pc_next;
        logic [XLEN-1:0]       inst;
        logic                  ecall;
        logic                  ebreak;
        logic                  skip;
    } wbu_instr_t;

endpackage

// File: rtl/ysyx_23060059_wbu_if.sv
// LSU->WBU retire bus and WBU->IFU next-PC handshake.
//   receive_valid/receive_ready : retire pulse from LSU and buffer-free back-pressure
//   wd_i .. skip_d_i            : retiring instruction payload
//   send_valid/send_ready/dnpc  : next fetch PC toward the IFU
// master: the surrounding pipeline (LSU + IFU side); slave: the WBU.
interface ysyx_23060059_wbu_if;
    import ysyx_23060059_pkg::*;

    logic                  receive_valid;
    logic                  receive_ready;
    logic [XLEN-1:0]       wd_i;
    logic [XLEN-1:0]       csr_wd_i;
    logic [GPR_ADDR_W-1:0] rd_i;
    logic [CSR_ADDR_W-1:0] csr_rd_i;
    logic                  reg_en_i;
    logic                  csreg_en_i;
    logic [XLEN-1:0]       pc_i;
    logic [XLEN-1:0]       pc_next_i;
    logic [XLEN-1:0]       instruction_i;
    logic                  ecall_i;
    logic                  ebreak_i;
    logic                  skip_d_i;
    logic                  send_valid;
    logic                  send_ready;
    logic [XLEN-1:0]       dnpc;

    modport master (
        output receive_valid, wd_i, csr_wd_i, rd_i, csr_rd_i, reg_en_i, csreg_en_i,
               pc_i, pc_next_i, instruction_i, ecall_i, ebreak_i, skip_d_i, send_ready,
        input  receive_ready, send_valid, dnpc
    );

    modport slave (
        input  receive_valid, wd_i, csr_wd_i, rd_i, csr_rd_i, reg_en_i, csreg_en_i,
               pc_i, pc_next_i, instruction_i, ecall_i, ebreak_i, skip_d_i, send_ready,
        output receive_ready, send_valid, dnpc
    );

endinterface

// File: rtl/ysyx_23060059_regfile.sv
// 32 x 32 general-purpose register file.
//   clock, reset        : clock, synchronous active-high reset (all regs to 0)
//   we_i/waddr_i/wdata_i: single write port, writes to x0 are dropped
//   raddr1_i/raddr2_i   : asynchronous read addresses
//   rdata1_o/rdata2_o   : read data, x0 always reads 0, no write bypass
module ysyx_23060059_regfile
    import ysyx_23060059_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [GPR_ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [GPR_ADDR_W-1:0] raddr1_i,
    input  logic [GPR_ADDR_W-1:0] raddr2_i,
    output logic [XLEN-1:0]       rdata1_o,
    output logic [XLEN-1:0]       rdata2_o
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/ysyx_23060059_wbu.sv
// Write-back unit: last pipeline stage after the LSU.
//   clock, reset          : clock, synchronous active-high reset
//   bus (slave)           : LSU retire bus in, IFU next-PC handshake out
//   rs1/rs2_addr, _data   : combinational GPR reads for the IDU
//   csr_raddr, csr_rdata  : combinational CSR read for the IDU
//   rd_wbu_to_idu,
//   csr_rd_wbu_to_idu     : destinations still in flight here (0 if none)
//   commit_*, difftest_skip, halt, instret : retire trace and status
// One instruction is committed per IDLE->COMMIT->REDIRECT round; a pulse
// arriving while busy is parked in a one-entry skid buffer.
module ysyx_23060059_wbu #(
    parameter logic [31:0] RESET_PC    = ysyx_23060059_pkg::RESET_PC,
    parameter logic [31:0] ECALL_CAUSE = ysyx_23060059_pkg::ECALL_CAUSE
) (
    input  logic                clock,
    input  logic                reset,
    ysyx_23060059_wbu_if.slave  bus,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic [31:0]         rs1_data,
    output logic [31:0]         rs2_data,
    input  logic [1:0]          csr_raddr,
    output logic [31:0]         csr_rdata,
    output logic [4:0]          rd_wbu_to_idu,
    output logic [1:0]          csr_rd_wbu_to_idu,
    output logic                commit_valid,
    output logic [31:0]         commit_pc,
    output logic [31:0]         commit_inst,
    output logic                difftest_skip,
    output logic                halt,
    output logic [63:0]         instret
);
    import ysyx_23060059_pkg::*;

    wbu_state_e  state_q;
    wbu_instr_t  in_instr_d;
    wbu_instr_t  cur_q;
    wbu_instr_t  buf_q;
    logic        cur_v_q;
    logic        buf_v_q;
    logic        send_valid_q;
    logic [31:0] dnpc_q;
    logic        commit_valid_q;
    logic [31:0] commit_pc_q;
    logic [31:0] commit_inst_q;
    logic        skip_q;
    logic        halt_q;
    logic [63:0] instret_q;
    logic [31:0] csr_q [4];

    logic load_from_buf;
    logic load_from_in;
    logic capture_buf;
    logic commit_fire;
    logic cur_in_flight;

    assign in_instr_d = '{
        wd:       bus.wd_i,
        csr_wd:   bus.csr_wd_i,
        rd:       bus.rd_i,
        csr_rd:   bus.csr_rd_i,
        reg_en:   bus.reg_en_i,
        csreg_en: bus.csreg_en_i,
        pc:       bus.pc_i,
        pc_next:  bus.pc_next_i,
        inst:     bus.instruction_i,
        ecall:    bus.ecall_i,
        ebreak:   bus.ebreak_i,
        skip:     bus.skip_d_i
    };

    // The buffer has priority over a fresh pulse so retire order is preserved.
    assign load_from_buf = (state_q == WBU_IDLE) && buf_v_q;
    assign load_from_in  = (state_q == WBU_IDLE) && !buf_v_q && bus.receive_valid;
    // HALT is terminal: pulses are dropped there and the buffer stays frozen.
    assign capture_buf   = bus.receive_valid && !buf_v_q &&
                           (state_q != WBU_IDLE) && (state_q != WBU_HALT);
    assign commit_fire   = (state_q == WBU_COMMIT);
    assign cur_in_flight = cur_v_q &&
                           ((state_q == WBU_COMMIT) || (state_q == WBU_REDIRECT));

    ysyx_23060059_regfile u_regfile (
        .clock    (clock),
        .reset    (reset),
        .we_i     (commit_fire && cur_q.reg_en),
        .waddr_i  (cur_q.rd),
        .wdata_i  (cur_q.wd),
        .raddr1_i (rs1_addr),
        .raddr2_i (rs2_addr),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    // Payload staging: no reset needed, qualified by the control flags below.
    always_ff @(posedge clock) begin
        if (load_from_buf) begin
            cur_q <= buf_q;
        end else if (load_from_in) begin
            cur_q <= in_instr_d;
        end
        if (capture_buf) begin
            buf_q <= in_instr_d;
        end
        if (commit_fire) begin
            commit_pc_q   <= cur_q.pc;
            commit_inst_q <= cur_q.inst;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // Boot goes through REDIRECT so the IFU is handed RESET_PC.
            state_q          <= WBU_REDIRECT;
            cur_v_q          <= 1'b0;
            buf_v_q          <= 1'b0;
            send_valid_q     <= 1'b0;
            dnpc_q           <= RESET_PC;
            commit_valid_q   <= 1'b0;
            skip_q           <= 1'b0;
            halt_q           <= 1'b0;
            instret_q        <= '0;
            csr_q[CSR_MSTATUS] <= MSTATUS_RESET;
            csr_q[CSR_MTVEC]   <= '0;
            csr_q[CSR_MEPC]    <= '0;
            csr_q[CSR_MCAUSE]  <= '0;
        end else begin
            commit_valid_q <= 1'b0;
            skip_q         <= 1'b0;
            if (capture_buf) begin
                buf_v_q <= 1'b1;
            end
            unique case (state_q)
                WBU_IDLE: begin
                    if (buf_v_q) begin
                        buf_v_q <= 1'b0;
                        cur_v_q <= 1'b1;
                        state_q <= WBU_COMMIT;
                    end else if (bus.receive_valid) begin
                        cur_v_q <= 1'b1;
                        state_q <= WBU_COMMIT;
                    end
                end
                WBU_COMMIT: begin
                    // ecall owns the CSR write port this cycle.
                    if (cur_q.ecall) begin
                        csr_q[CSR_MEPC]   <= cur_q.pc;
                        csr_q[CSR_MCAUSE] <= ECALL_CAUSE;
                        dnpc_q            <= csr_q[CSR_MTVEC];
                    end else begin
                        if (cur_q.csreg_en) begin
                            csr_q[cur_q.csr_rd] <= cur_q.csr_wd;
                        end
                        dnpc_q <= cur_q.pc_next;
                    end
                    commit_valid_q <= 1'b1;
                    skip_q         <= cur_q.skip;
                    instret_q      <= instret_q + 64'd1;
                    if (cur_q.ebreak) begin
                        halt_q  <= 1'b1;
                        state_q <= WBU_HALT;
                    end else begin
                        send_valid_q <= 1'b1;
                        state_q      <= WBU_REDIRECT;
                    end
                end
                WBU_REDIRECT: begin
                    // First cycle out of reset raises send_valid here.
                    if (!send_valid_q) begin
                        send_valid_q <= 1'b1;
                    end else if (bus.send_ready) begin
                        send_valid_q <= 1'b0;
                        cur_v_q      <= 1'b0;
                        state_q      <= WBU_IDLE;
                    end
                end
                WBU_HALT: begin
                end
                default: state_q <= WBU_IDLE;
            endcase
        end
    end

    // A second pulse while the buffer is occupied would be lost.
    always_ff @(posedge clock) begin
        if (!reset && (state_q != WBU_HALT)) begin
            assert (!(bus.receive_valid && buf_v_q))
                else $error("wbu: receive_valid while skid buffer is full");
        end
    end

    always_comb begin
        rd_wbu_to_idu     = '0;
        csr_rd_wbu_to_idu = '0;
        if (cur_in_flight && cur_q.reg_en) begin
            rd_wbu_to_idu = cur_q.rd;
        end else if (buf_v_q && buf_q.reg_en) begin
            rd_wbu_to_idu = buf_q.rd;
        end
        if (cur_in_flight && cur_q.csreg_en) begin
            csr_rd_wbu_to_idu = cur_q.csr_rd;
        end else if (buf_v_q && buf_q.csreg_en) begin
            csr_rd_wbu_to_idu = buf_q.csr_rd;
        end
    end

    assign bus.receive_ready = !buf_v_q;
    assign bus.send_valid    = send_valid_q;
    assign bus.dnpc          = dnpc_q;
    assign csr_rdata         = csr_q[csr_raddr];
    assign commit_valid      = commit_valid_q;
    assign commit_pc         = commit_pc_q;
    assign commit_inst       = commit_inst_q;
    assign difftest_skip     = skip_q;
    assign halt              = halt_q;
    assign instret           = instret_q;

endmodule
